// File: rtl/multiword_add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_sequencer_pkg
// Purpose  : Shared state encoding and sizing helpers for the multi-word adder.
// Revision : 1.0  initial release
// ============================================================================

`ifndef MULTIWORD_ADD_SEQUENCER_WORD_SEL
`define MULTIWORD_ADD_SEQUENCER_WORD_SEL
`define WORD_SEL(vec, i, w) vec[(i)*(w) +: (w)]
`endif

package multiword_add_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // A single-word build still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : ripple_carry_adder
// Purpose  : WIDTH-bit ripple-carry adder with carry in and carry out.
// Revision : 1.0  initial release
// ============================================================================

module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[WIDTH];

endmodule

`default_nettype wire

// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_sequencer
// Purpose  : Multi-precision add/sub, one WIDTH-bit word per cycle, LSW first.
// Revision : 1.0  initial release
// ============================================================================

module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] in_a,
    input  logic [WIDTH*WORDS-1:0] in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int              IW         = idx_width(WORDS);
    localparam int              TW         = WIDTH * WORDS;
    localparam logic [IW-1:0]   C_LAST_IDX = IW'(WORDS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [TW-1:0]     r_a;
    logic [TW-1:0]     r_b;
    logic [TW-1:0]     r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic [IW-1:0]     r_idx;

    logic [WIDTH-1:0]  w_a_word;
    logic [WIDTH-1:0]  w_b_word;
    logic [WIDTH-1:0]  w_sum_word;
    logic              w_cout;
    logic              w_accept;
    logic              w_last;

    assign w_a_word = `WORD_SEL(r_a, r_idx, WIDTH);
    assign w_b_word = `WORD_SEL(r_b, r_idx, WIDTH);
    assign w_last   = (r_idx == C_LAST_IDX);
    assign w_accept = in_valid & in_ready;

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_sum_word),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Subtraction is folded in at capture: B is stored inverted and the
    // carry register seeds the +1 of the two's complement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= in_a;
                        r_b     <= in_sub ? ~in_b : in_b;
                        r_carry <= in_sub;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    `WORD_SEL(r_sum, r_idx, WIDTH) <= w_sum_word;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_cout;
                        r_ovf  <= (r_a[TW-1] == r_b[TW-1]) &&
                                  (w_sum_word[WIDTH-1] != r_a[TW-1]);
                    end else begin
                        r_idx  <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiword_add_sequencer
// Purpose  : Self-checking bench for the 4x8 build plus a 1x8 build.
// Revision : 1.0  initial release
// ============================================================================

module tb_multiword_add_sequencer;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TW = W * N;

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          sub;
        logic [TW-1:0] sum;
        logic          cout;
        logic          ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf, busy;
    logic [TW-1:0] in_a, in_b, out_sum;

    logic          u1_in_valid, u1_in_ready, u1_in_sub, u1_out_valid, u1_out_ready;
    logic          u1_out_cout, u1_out_ovf, u1_busy;
    logic [W-1:0]  u1_in_a, u1_in_b, u1_out_sum;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    multiword_add_sequencer #(.WIDTH(W), .WORDS(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .out_ovf(out_ovf), .busy(busy)
    );

    multiword_add_sequencer #(.WIDTH(W), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
        .in_a(u1_in_a), .in_b(u1_in_b), .in_sub(u1_in_sub), .out_valid(u1_out_valid),
        .out_ready(u1_out_ready), .out_sum(u1_out_sum), .out_cout(u1_out_cout),
        .out_ovf(u1_out_ovf), .busy(u1_busy)
    );

    function automatic vec_t mk(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic sub);
        vec_t          v;
        logic [TW-1:0] be;
        logic [TW:0]   t;
        be     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, be} + {{TW{1'b0}}, sub};
        v.a    = a;
        v.b    = b;
        v.sub  = sub;
        v.sum  = t[TW-1:0];
        v.cout = t[TW];
        v.ovf  = (a[TW-1] == be[TW-1]) && (t[TW-1] != a[TW-1]);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request, hold it until accepted, push its expectation.
    task automatic issue(input vec_t v);
        int t;
        t        = 0;
        in_a     = v.a;
        in_b     = v.b;
        in_sub   = v.sub;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready got 0, expected 1");
        end
        tick();
        sb.push_back(v);
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, checking latency and in_ready, then compare the head of the scoreboard.
    task automatic collect(input string nm);
        int   lat;
        vec_t e;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk({nm, "_in_ready_busy"}, {63'd0, in_ready}, 64'd0);
            tick();
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(N));
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_sb_empty: got 0 entries, expected 1", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_sum"},  {32'd0, out_sum},  {32'd0, e.sum});
            chk({nm, "_cout"}, {63'd0, out_cout}, {63'd0, e.cout});
            chk({nm, "_ovf"},  {63'd0, out_ovf},  {63'd0, e.ovf});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        chk({nm, "_ready_back"}, {63'd0, in_ready},  64'd1);
    endtask

    initial begin
        vec_t v1, v2, e;

        vecs[0]  = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3]  = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5]  = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        for (int i = 8; i < 12; i++)
            vecs[i] = mk($urandom, $urandom, 1'($urandom_range(0, 1)));

        rst = 1'b1;  in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0;   in_b = '0;       in_sub = 1'b0;
        u1_in_valid = 1'b0; u1_out_ready = 1'b0;
        u1_in_a = '0; u1_in_b = '0;   u1_in_sub = 1'b0;

        tick();
        tick();
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum",   {32'd0, out_sum},   64'd0);
        chk("rst_cout_ovf",  {62'd0, out_cout, out_ovf}, 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("idle_busy",     {63'd0, busy},     64'd0);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i]);
            collect($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while a new request waits.
        v1 = mk(32'h11111111, 32'h22222222, 1'b0);
        v2 = mk(32'h00000010, 32'h00000003, 1'b1);
        issue(v1);
        for (int t = 0; t < 20 && !out_valid; t++) tick();
        e        = sb.pop_front();
        in_a     = v2.a;
        in_b     = v2.b;
        in_sub   = v2.sub;
        in_valid = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("bp_valid",    {63'd0, out_valid}, 64'd1);
            chk("bp_sum",      {32'd0, out_sum},   {32'd0, e.sum});
            chk("bp_flags",    {62'd0, out_cout, out_ovf}, {62'd0, e.cout, e.ovf});
            chk("bp_in_ready", {63'd0, in_ready},  64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        sb.push_back(v2);
        in_valid = 1'b0;
        chk("bp_queued_accept", {63'd0, busy}, 64'd1);
        collect("bp_queued");

        // Reset while RUN is at word index 2.
        issue(mk(32'hAAAAAAAA, 32'h55555555, 1'b0));
        void'(sb.pop_back());
        tick();
        tick();
        chk("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_sum",   {32'd0, out_sum},   64'd0);
        chk("abort_idle",  {62'd0, busy, in_ready}, 64'd1);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
        end
        issue(mk(32'h12345678, 32'h11111111, 1'b0));
        collect("post_abort");

        // Single-word build: one RUN cycle.
        u1_in_a = 8'hFF; u1_in_b = 8'h01; u1_in_sub = 1'b0; u1_in_valid = 1'b1;
        chk("w1_ready", {63'd0, u1_in_ready}, 64'd1);
        tick();
        u1_in_valid = 1'b0;
        chk("w1_not_yet", {63'd0, u1_out_valid}, 64'd0);
        tick();
        chk("w1_valid", {63'd0, u1_out_valid}, 64'd1);
        chk("w1_sum",   {56'd0, u1_out_sum},   64'd0);
        chk("w1_cout",  {63'd0, u1_out_cout},  64'd1);
        chk("w1_ovf",   {63'd0, u1_out_ovf},   64'd0);
        u1_out_ready = 1'b1;
        tick();
        u1_out_ready = 1'b0;
        chk("w1_drop",  {63'd0, u1_out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
